muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle controller and iterative datapath for the RV32M multiply/divide instructions. It sits in the execute stage beside the single-cycle ALU. It accepts one operation per start, stalls the pipeline while it iterates, and returns a 32-bit result with a one-cycle done pulse. All sequencing, operand latching, sign handling and special-case shortcuts live here.

Parameters:
XLEN, 32, operand/result width; only 32 is required to be supported.
ITER, XLEN, number of CALC iterations (one bit per cycle).

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request an operation; sampled only in IDLE
op  in  3  Funct3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  XLEN  rs1 operand (multiplicand/dividend)
src_b  in  XLEN  rs2 operand (multiplier/divisor)
flush  in  1  abort the current operation (branch mispredict/trap)
busy  out  1  high in CALC and FIX
stall  out  1  combinational: (IDLE & start & !flush) | CALC | FIX
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  operation result; holds until the next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, internal registers cleared. Reset has priority over flush and start, including mid-operation.
- States:
  - IDLE: start & !flush latches op, src_a, src_b. It goes to DONE if a special case applies, else to CALC with count=0.
  - CALC: performs one radix-2 step per cycle: shift-add for MUL*, restoring subtract for DIV*/REM*. count increments; at count==ITER-1 it goes to FIX.
  - FIX: applies sign correction (negate product/quotient/remainder as required), selects high/low half, then goes to DONE.
  - DONE: done=1, result updated, goes to IDLE.
- Latency, normal path: start seen in cycle 0; CALC covers cycles 1..32; FIX in cycle 33; done=1 in cycle 34.
- Latency, special case: start seen in cycle 0; done=1 in cycle 1.
- Operands are absolute-valued at latch per signedness. MUL/MULH are signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned. MUL returns the low 32 bits of the 64-bit product; MULH* return the high 32 bits.
- Special cases, per RISC-V spec:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src_a.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- start while not in IDLE is ignored; no queueing.
- flush in CALC/FIX/DONE: next state is IDLE, done is suppressed, result is unchanged.
- flush in IDLE together with start: the start is ignored.
- done is never high two consecutive cycles. Input changes after the latch cycle have no effect.

Decomposition:
- muldiv_pkg holds:
  - op encoding enum (MD_MUL..MD_REMU, 3-bit)
  - state enum (IDLE, CALC, FIX, DONE)
  - XLEN-wide constants ALL_ONES and INT_MIN
  - function is_div(op)
  - function is_signed_a(op) and is_signed_b(op)
- Single module; the iterative datapath (64-bit accumulator/remainder register, shift/subtract step) is small enough to stay inline. No sub-module is required.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), start at cycle 0 -> stall high cycles 0..33, done at cycle 34, result 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 -> result 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> done at cycle 1, result 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> done at cycle 1, result 0x80000000.
- flush asserted at cycle 10 of a DIV -> busy=0 at cycle 11, no done pulse, result keeps its previous value. A new start at cycle 12 completes normally at cycle 46.
- start pulsed again at cycle 5 while busy with different operands -> ignored, first result intact. reset at cycle 20 -> IDLE, busy=0, result=0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - md_op_e    : funct3 encoding of the M-extension operations
//   - md_state_e : sequencer states
//   - ALL_ONES / INT_MIN : XLEN-wide constants used by the divide shortcuts
//   - is_div / is_rem / is_signed_a / is_signed_b : operation classifiers
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [MD_XLEN-1:0] ALL_ONES = {MD_XLEN{1'b1}};
  localparam logic [MD_XLEN-1:0] INT_MIN  = {1'b1, {(MD_XLEN-1){1'b0}}};

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV and REM.
  function automatic logic is_signed_b(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Operands are converted to magnitudes at latch time, a radix-2 shift-add
// (multiply) or restoring-subtract (divide) runs for ITER cycles, and the
// sign is restored in a single FIX cycle. Divide-by-zero and signed overflow
// bypass the iteration and complete on the cycle after start.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : request and funct3 of the operation (sampled in IDLE)
//   src_a, src_b     : rs1 / rs2 operands
//   flush            : abort any operation in flight
//   busy             : iterating or fixing up
//   stall            : pipeline hold request (combinational)
//   done             : one-cycle result-valid pulse
//   result           : last completed result, held until the next done
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e         state_reg, state_next;
  md_op_e            op_reg;
  logic [CW-1:0]     count_reg;
  logic [XLEN-1:0]   opnd_reg;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_reg;     // {product hi, multiplier} or {remainder, quotient}
  logic              neg_reg;     // product/quotient must be negated
  logic              rem_neg_reg; // remainder must be negated (dividend negative)
  logic [XLEN-1:0]   pend_reg;    // result waiting to be published in DONE
  logic [XLEN-1:0]   result_reg;

  md_op_e          op_in;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special;
  logic [XLEN-1:0] special_val;

  assign op_in = md_op_e'(op);

  // Operand conditioning and divide shortcuts, evaluated on the raw inputs.
  always_comb begin
    sign_a      = is_signed_a(op_in) & src_a[XLEN-1];
    sign_b      = is_signed_b(op_in) & src_b[XLEN-1];
    abs_a       = sign_a ? -src_a : src_a;
    abs_b       = sign_b ? -src_b : src_b;
    special     = 1'b0;
    special_val = '0;
    if (is_div(op_in)) begin
      if (src_b == '0) begin
        special     = 1'b1;
        special_val = is_rem(op_in) ? src_a : ALL_ONES;
      end else if (is_signed_a(op_in) && (src_a == INT_MIN) && (src_b == ALL_ONES)) begin
        special     = 1'b1;
        special_val = is_rem(op_in) ? '0 : INT_MIN;
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start && !flush) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)                               state_next = IDLE;
        else if (count_reg == CW'(ITER - 1))     state_next = FIX;
      end
      FIX:  state_next = flush ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // done and the published value are gated by flush/reset in the DONE cycle
  // so an abort there leaves result untouched and emits no pulse.
  always_comb begin
    busy   = (state_reg == CALC) || (state_reg == FIX);
    stall  = ((state_reg == IDLE) && start && !flush) || busy;
    done   = (state_reg == DONE) && !flush && !reset;
    result = done ? pend_reg : result_reg;
  end

  // ---------------- datapath step / fix-up ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              borrow;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    // Divide: shift the next dividend bit into the partial remainder; the
    // shifted remainder can be one bit wider than the divisor.
    rem_sh  = acc_reg[2*XLEN-1:XLEN-1];
    borrow  = rem_sh < {1'b0, opnd_reg};
    diff    = rem_sh[XLEN-1:0] - opnd_reg;
    if (is_div(op_reg))
      acc_step = {(borrow ? rem_sh[XLEN-1:0] : diff), acc_reg[XLEN-2:0], ~borrow};
    else
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};

    prod_fix = neg_reg     ? -acc_reg                  : acc_reg;
    quot_fix = neg_reg     ? -acc_reg[XLEN-1:0]        : acc_reg[XLEN-1:0];
    rem_fix  = rem_neg_reg ? -acc_reg[2*XLEN-1:XLEN]   : acc_reg[2*XLEN-1:XLEN];
    unique case (op_reg)
      MD_MUL:                         fix_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:   fix_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:                fix_val = quot_fix;
      default:                        fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= MD_MUL;
      count_reg   <= '0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      pend_reg    <= '0;
      result_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            op_reg      <= op_in;
            count_reg   <= '0;
            neg_reg     <= sign_a ^ sign_b;
            rem_neg_reg <= sign_a;
            if (is_div(op_in)) begin
              opnd_reg <= abs_b;
              acc_reg  <= {{XLEN{1'b0}}, abs_a};
            end else begin
              opnd_reg <= abs_a;
              acc_reg  <= {{XLEN{1'b0}}, abs_b};
            end
            if (special) pend_reg <= special_val;
          end
        end
        CALC: begin
          acc_reg   <= acc_step;
          count_reg <= count_reg + CW'(1);
        end
        FIX:  pend_reg <= fix_val;
        DONE: if (!flush) result_reg <= pend_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the RV32M arithmetic rules, using 64-bit math.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    int          ia, ib, iq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        iq = ia / ib; return iq;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        iq = ia % ib; return iq;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Issues one operation starting at the current cycle (called at posedge+1).
  // Optional flush / extra start / reset are injected at given relative cycles.
  // Returns at posedge+1 after the cycle following done, or after max_cyc cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at, input int reset_at,
                        input int max_cyc,
                        output int lat, output int stall_cnt, output int done_cnt,
                        output logic [31:0] res, output logic busy_chk,
                        output logic [31:0] res_chk);
    int probe;
    lat = -1; stall_cnt = 0; done_cnt = 0; res = 'x; busy_chk = 1'bx; res_chk = 'x;
    probe = (flush_at >= 0) ? flush_at + 1 : ((reset_at >= 0) ? reset_at + 1 : -1);
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin lat = cyc; res = result; end
      end
      if (cyc == probe) begin busy_chk = busy; res_chk = result; end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; reset = 1'b0;
      if (cyc + 1 == flush_at) flush = 1'b1;
      if (cyc + 1 == reset_at) reset = 1'b1;
      if (cyc + 1 == poke_at) begin
        start = 1'b1; op = o ^ 3'b001; src_a = $urandom; src_b = $urandom;
      end
      if (lat >= 0 && cyc >= lat + 1) break;
    end
  endtask

  vec_t        vecs[12];
  int          lat, stall_cnt, done_cnt;
  logic [31:0] res, res_chk, exp_r, ra, rb;
  logic        busy_chk;
  logic [2:0]  ro;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,         34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, -1, -1, -1, 80,
             lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_stall_cycles", i), stall_cnt, vecs[i].lat);
      chk($sformatf("vec%0d_done_count", i), done_cnt, 32'd1);
      $display("vec %0d op=%0d a=0x%08h b=0x%08h -> result=0x%08h latency=%0d",
               i, vecs[i].o, vecs[i].a, vecs[i].b, res, lat);
    end

    // Flush at cycle 10 of a DIV: prior result 14 must survive.
    run_op(3'd5, 32'd100, 32'd7, -1, -1, -1, 80,
           lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
    chk("preflush_result", res, 32'd14);
    run_op(3'd4, 32'hFFFF_0000, 32'd3, 10, -1, -1, 12,
           lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
    chk("flush_busy", {31'd0, busy_chk}, 32'd0);
    chk("flush_result_held", res_chk, 32'd14);
    chk("flush_no_done", done_cnt, 32'd0);
    $display("flush: busy=%0d result=0x%08h dones=%0d", busy_chk, res_chk, done_cnt);
    // Restart immediately (cycle 12 of the flushed sequence) -> done at cycle 46.
    run_op(3'd6, 32'hFFFF_0000, 32'd7, -1, -1, -1, 80,
           lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
    chk("after_flush_result", res, model(3'd6, 32'hFFFF_0000, 32'd7));
    chk("after_flush_latency", lat, 32'd34);
    $display("after flush: result=0x%08h latency=%0d", res, lat);

    // Second start while busy is ignored.
    run_op(3'd4, 32'd1000, 32'd7, -1, 5, -1, 80,
           lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
    chk("poke_result", res, 32'd142);
    chk("poke_latency", lat, 32'd34);
    chk("poke_done_count", done_cnt, 32'd1);
    $display("ignored start: result=0x%08h latency=%0d", res, lat);

    // Reset mid-operation.
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, -1, -1, 20, 60,
           lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
    chk("midreset_busy", {31'd0, busy_chk}, 32'd0);
    chk("midreset_result", res_chk, 32'd0);
    chk("midreset_no_done", done_cnt, 32'd0);
    $display("mid reset: busy=%0d result=0x%08h dones=%0d", busy_chk, res_chk, done_cnt);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      exp_r = model(ro, ra, rb);
      run_op(ro, ra, rb, -1, -1, -1, 80,
             lat, stall_cnt, done_cnt, res, busy_chk, res_chk);
      chk($sformatf("rand%0d_result", i), res, exp_r);
      chk($sformatf("rand%0d_latency", i), lat, model_lat(ro, ra, rb));
      $display("rand %0d op=%0d a=0x%08h b=0x%08h -> result=0x%08h expected=0x%08h latency=%0d",
               i, ro, ra, rb, res, exp_r, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
